// File: rtl/complex_div.sv
`default_nettype none
// ============================================================================
// Module   : complex_div
// Purpose  : Sequential complex divider y = a*conj(b)/|b|^2 on signed Q(NB_W,NBF_W)
//            operands. A bit-serial restoring divider runs I and Q in parallel.
//            The result saturates symmetrically. Build macro CDIV_ROUND_EN adds a
//            guard bit and rounds the result half away from zero.
// Revision : 1.0 - initial release
// ============================================================================
module complex_div #(
    parameter int NB_W  = 17,
    parameter int NBF_W = 10
) (
    input  logic            i_clk,
    input  logic            i_rst,
    input  logic            i_valid,
    output logic            o_ready,
    input  logic [NB_W-1:0] i_aI,
    input  logic [NB_W-1:0] i_aQ,
    input  logic [NB_W-1:0] i_bI,
    input  logic [NB_W-1:0] i_bQ,
    output logic            o_valid,
    input  logic            i_ready,
    output logic [NB_W-1:0] o_yI,
    output logic [NB_W-1:0] o_yQ,
    output logic            o_div0
);

`ifdef CDIV_ROUND_EN
    localparam int c_RND = 1;
`else
    localparam int c_RND = 0;
`endif
    localparam int c_Q_IT = NB_W - 1 + c_RND;
    localparam int c_PW   = 2*NB_W + 1;
    localparam int c_DW   = 2*NB_W;
    localparam int c_XW   = 3*NB_W + 2;
    localparam int c_CW   = $clog2(c_Q_IT + 1);
    localparam logic [NB_W-1:0] c_MAXMAG = {1'b0, {(NB_W-1){1'b1}}};

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LOAD = 2'd1,
        S_DIV  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t r_state, w_state_nxt;

    logic signed [NB_W-1:0] r_aI, r_aQ, r_bI, r_bQ;
    logic                   r_lz;
    logic [c_XW-1:0]        r_dsh;
    logic [c_XW-1:0]        r_rem [2];
    logic [c_Q_IT-1:0]      r_q   [2];
    logic                   r_neg [2];
    logic                   r_ovf [2];
    logic [c_CW-1:0]        r_cnt;

    logic signed [c_PW-1:0] w_aIx, w_aQx, w_bIx, w_bQx;
    logic signed [c_PW-1:0] w_n   [2];
    logic [c_PW-1:0]        w_abs [2];
    logic [c_DW-1:0]        w_d;
    logic                   w_dz;
    logic                   w_ge      [2];
    logic [c_XW-1:0]        w_rem_nxt [2];
    logic [c_Q_IT-1:0]      w_q_nxt   [2];
    logic                   w_last;

    // Quotient magnitude to signed output; a zero magnitude stays +0.
    function automatic logic [NB_W-1:0] f_final(input logic [c_Q_IT-1:0] q,
                                                input logic ovf, input logic neg);
        logic [NB_W-1:0] mag;
`ifdef CDIV_ROUND_EN
        logic [NB_W:0] t;
        t   = (NB_W+1)'(q) + (NB_W+1)'(1);
        mag = NB_W'(t >> 1);
        if (mag[NB_W-1]) mag = c_MAXMAG;
`else
        mag = NB_W'(q);
`endif
        if (ovf) mag = c_MAXMAG;
        return neg ? -mag : mag;
    endfunction

    // Full-precision numerator and denominator, no rounding.
    always_comb begin
        w_aIx = c_PW'(r_aI);
        w_aQx = c_PW'(r_aQ);
        w_bIx = c_PW'(r_bI);
        w_bQx = c_PW'(r_bQ);
        w_n[0] = w_aIx*w_bIx + w_aQx*w_bQx;
        w_n[1] = w_aQx*w_bIx - w_aIx*w_bQx;
        w_d    = c_DW'(w_bIx*w_bIx + w_bQx*w_bQx);
        w_dz   = (w_d == '0);
        for (int k = 0; k < 2; k++) begin
            w_abs[k] = w_n[k][c_PW-1] ? c_PW'(-w_n[k]) : c_PW'(w_n[k]);
        end
    end

    always_comb begin
        for (int k = 0; k < 2; k++) begin
            w_ge[k]      = (r_rem[k] >= r_dsh);
            w_rem_nxt[k] = w_ge[k] ? (r_rem[k] - r_dsh) : r_rem[k];
            w_q_nxt[k]   = (r_q[k] << 1) | c_Q_IT'(w_ge[k]);
        end
        w_last = (r_cnt == c_CW'(c_Q_IT - 1));
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) r_state <= S_IDLE;
        else       r_state <= w_state_nxt;
    end

    // A zero denominator spends a second cycle in LOAD, decided from r_lz.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: if (i_valid) w_state_nxt = S_LOAD;
            S_LOAD: begin
                if (r_lz)       w_state_nxt = S_DONE;
                else if (!w_dz) w_state_nxt = S_DIV;
            end
            S_DIV:  if (w_last)  w_state_nxt = S_DONE;
            S_DONE: if (i_ready) w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    assign o_ready = (r_state == S_IDLE);
    assign o_valid = (r_state == S_DONE);

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_aI   <= '0;
            r_aQ   <= '0;
            r_bI   <= '0;
            r_bQ   <= '0;
            r_lz   <= 1'b0;
            r_dsh  <= '0;
            r_cnt  <= '0;
            o_yI   <= '0;
            o_yQ   <= '0;
            o_div0 <= 1'b0;
            for (int k = 0; k < 2; k++) begin
                r_rem[k] <= '0;
                r_q[k]   <= '0;
                r_neg[k] <= 1'b0;
                r_ovf[k] <= 1'b0;
            end
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (i_valid) begin
                        r_aI <= i_aI;
                        r_aQ <= i_aQ;
                        r_bI <= i_bI;
                        r_bQ <= i_bQ;
                    end
                end
                S_LOAD: begin
                    if (r_lz) begin
                        r_lz   <= 1'b0;
                        o_yI   <= '0;
                        o_yQ   <= '0;
                        o_div0 <= 1'b1;
                    end else begin
                        r_lz  <= w_dz;
                        r_cnt <= '0;
                        // Divisor pre-aligned to the quotient MSB position.
                        r_dsh <= c_XW'(w_d) << (c_Q_IT - 1);
                        for (int k = 0; k < 2; k++) begin
                            r_neg[k] <= w_n[k][c_PW-1];
                            r_q[k]   <= '0;
                            r_rem[k] <= c_XW'(w_abs[k]) << (NBF_W + c_RND);
                            r_ovf[k] <= (c_XW'(w_abs[k]) << NBF_W) >= (c_XW'(w_d) << (NB_W - 1));
                        end
                    end
                end
                S_DIV: begin
                    r_cnt <= r_cnt + c_CW'(1);
                    r_dsh <= r_dsh >> 1;
                    for (int k = 0; k < 2; k++) begin
                        r_rem[k] <= w_rem_nxt[k];
                        r_q[k]   <= w_q_nxt[k];
                    end
                    if (w_last) begin
                        o_yI   <= f_final(w_q_nxt[0], r_ovf[0], r_neg[0]);
                        o_yQ   <= f_final(w_q_nxt[1], r_ovf[1], r_neg[1]);
                        o_div0 <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_complex_div.sv
`default_nettype none
// ============================================================================
// Module   : tb_complex_div
// Purpose  : Self-checking bench for complex_div: fixed vectors, corner-case
//            sequences and random operands against an integer reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_complex_div;

`ifdef CDIV_ROUND_EN
    localparam int c_LAT = 18;
`else
    localparam int c_LAT = 17;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        i_valid;
    logic        i_ready;
    logic [16:0] i_aI, i_aQ, i_bI, i_bQ;
    logic        o_ready;
    logic        o_valid;
    logic [16:0] o_yI, o_yQ;
    logic        o_div0;

    int checks   = 0;
    int failures = 0;

    complex_div #(.NB_W(17), .NBF_W(10)) dut (
        .i_clk  (clk),
        .i_rst  (rst),
        .i_valid(i_valid),
        .o_ready(o_ready),
        .i_aI   (i_aI),
        .i_aQ   (i_aQ),
        .i_bI   (i_bI),
        .i_bQ   (i_bQ),
        .o_valid(o_valid),
        .i_ready(i_ready),
        .o_yI   (o_yI),
        .o_yQ   (o_yQ),
        .o_div0 (o_div0)
    );

    always #5 clk = ~clk;

    typedef struct {
        int aI, aQ, bI, bQ;
        int eI, eQ;
        int ediv0;
        int elat;
    } vec_t;

    task automatic check(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    // Reference: exact rational quotient in Q6.10, truncated or rounded, then saturated.
    function automatic longint ref_comp(input longint n, input longint d);
        longint m, mag;
        m = (n < 0) ? -n : n;
        if (m * 1024 >= d * 65536) mag = 65535;
        else begin
`ifdef CDIV_ROUND_EN
            mag = ((m * 2048) / d + 1) / 2;
            if (mag > 65535) mag = 65535;
`else
            mag = (m * 1024) / d;
`endif
        end
        return (n < 0) ? -mag : mag;
    endfunction

    task automatic model(input longint aI, aQ, bI, bQ,
                         output longint yI, yQ, output int dz);
        longint d;
        d = bI*bI + bQ*bQ;
        if (d == 0) begin
            yI = 0; yQ = 0; dz = 1;
        end else begin
            yI = ref_comp(aI*bI + aQ*bQ, d);
            yQ = ref_comp(aQ*bI - aI*bQ, d);
            dz = 0;
        end
    endtask

    // Issue one operation; returns at #1 after the edge o_valid rose (or timeout).
    task automatic run_op(input int aI, aQ, bI, bQ,
                          output int yI, yQ, output int dz, output int lat);
        int w;
        w = 0;
        while (!o_ready && w < 100) begin
            @(posedge clk); #1;
            w++;
        end
        if (!o_ready) begin
            checks++;
            failures++;
            $display("FAIL accept_timeout: waited=%0d cycles without o_ready", w);
        end
        i_valid = 1'b1;
        i_aI = 17'(aI); i_aQ = 17'(aQ); i_bI = 17'(bI); i_bQ = 17'(bQ);
        @(posedge clk); #1;
        i_valid = 1'b0;
        i_aI = 17'($urandom); i_aQ = 17'($urandom);
        i_bI = 17'($urandom); i_bQ = 17'($urandom);
        lat = 0;
        while (!o_valid && lat < 100) begin
            @(posedge clk); #1;
            lat++;
        end
        yI = int'($signed(o_yI));
        yQ = int'($signed(o_yQ));
        dz = int'(o_div0);
    endtask

    // With i_ready low the result must stay frozen; stray i_valid pulses are ignored.
    task automatic hold_check(input string tag, input int n, input int eI, eQ, edz);
        for (int c = 0; c < n; c++) begin
            i_valid = (c % 2 == 0);
            i_aI = 17'(1024); i_aQ = 17'(7); i_bI = 17'(512); i_bQ = 17'(3);
            @(posedge clk); #1;
            check($sformatf("%s_hold%0d_valid", tag, c), o_valid, 1);
            check($sformatf("%s_hold%0d_ready", tag, c), o_ready, 0);
            check($sformatf("%s_hold%0d_yI", tag, c), $signed(o_yI), eI);
            check($sformatf("%s_hold%0d_yQ", tag, c), $signed(o_yQ), eQ);
            check($sformatf("%s_hold%0d_div0", tag, c), o_div0, edz);
        end
        i_valid = 1'b0;
        i_ready = 1'b1;
        @(posedge clk); #1;
        check($sformatf("%s_release_valid", tag), o_valid, 0);
        check($sformatf("%s_release_ready", tag), o_ready, 1);
    endtask

    initial begin
        vec_t   tv [9];
        int     yI, yQ, dz, lat;
        longint mI, mQ;
        int     mdz;
        int     ra, rb, rc, rd, mode;

`ifdef CDIV_ROUND_EN
        tv[3] = '{2048, 0, 3072, 0, 683, 0, 0, c_LAT};
        tv[4] = '{-2048, 0, 3072, 0, -683, 0, 0, c_LAT};
`else
        tv[3] = '{2048, 0, 3072, 0, 682, 0, 0, c_LAT};
        tv[4] = '{-2048, 0, 3072, 0, -682, 0, 0, c_LAT};
`endif
        tv[0] = '{2048, 0, 1024, 0, 2048, 0, 0, c_LAT};
        tv[1] = '{1024, 0, 0, 1024, 0, -1024, 0, c_LAT};
        tv[2] = '{1024, 1024, 1024, 1024, 1024, 0, 0, c_LAT};
        tv[5] = '{32768, 0, 1, 0, 65535, 0, 0, c_LAT};
        tv[6] = '{-65536, 0, 1, 0, -65535, 0, 0, c_LAT};
        tv[7] = '{500, -3, 0, 0, 0, 0, 1, 2};
        tv[8] = '{-1, 0, 3072, 0, 0, 0, 0, c_LAT};

        rst = 1'b1; i_valid = 1'b0; i_ready = 1'b1;
        i_aI = '0; i_aQ = '0; i_bI = '0; i_bQ = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_ready", o_ready, 1);
        check("rst_valid", o_valid, 0);
        check("rst_yI", o_yI, 0);
        check("rst_yQ", o_yQ, 0);
        check("rst_div0", o_div0, 0);
        @(negedge clk);
        rst = 1'b0;

        // Divide-by-zero with backpressure
        i_ready = 1'b0;
        run_op(500, -3, 0, 0, yI, yQ, dz, lat);
        check("div0_yI", yI, 0);
        check("div0_yQ", yQ, 0);
        check("div0_flag", dz, 1);
        check("div0_lat", lat, 2);
        hold_check("div0", 5, 0, 0, 1);

        // Non-zero result under backpressure
        i_ready = 1'b0;
        run_op(tv[3].aI, tv[3].aQ, tv[3].bI, tv[3].bQ, yI, yQ, dz, lat);
        check("bp_yI", yI, tv[3].eI);
        check("bp_lat", lat, c_LAT);
        hold_check("bp", 3, tv[3].eI, 0, 0);

        for (int i = 0; i < 9; i++) begin
            run_op(tv[i].aI, tv[i].aQ, tv[i].bI, tv[i].bQ, yI, yQ, dz, lat);
            check($sformatf("tv%0d_yI", i), yI, tv[i].eI);
            check($sformatf("tv%0d_yQ", i), yQ, tv[i].eQ);
            check($sformatf("tv%0d_div0", i), dz, tv[i].ediv0);
            check($sformatf("tv%0d_lat", i), lat, tv[i].elat);
        end

        for (int i = 0; i < 40; i++) begin
            mode = $urandom_range(0, 2);
            ra = int'($urandom_range(0, 131071)) - 65536;
            rb = int'($urandom_range(0, 131071)) - 65536;
            case (mode)
                0: begin
                    rc = int'($urandom_range(0, 131071)) - 65536;
                    rd = int'($urandom_range(0, 131071)) - 65536;
                end
                1: begin
                    rc = int'($urandom_range(0, 128)) - 64;
                    rd = int'($urandom_range(0, 128)) - 64;
                end
                default: begin
                    rc = int'($urandom_range(0, 4096)) - 2048;
                    rd = int'($urandom_range(0, 4096)) - 2048;
                end
            endcase
            model(ra, rb, rc, rd, mI, mQ, mdz);
            run_op(ra, rb, rc, rd, yI, yQ, dz, lat);
            check($sformatf("rnd%0d_yI a=(%0d,%0d) b=(%0d,%0d)", i, ra, rb, rc, rd), yI, mI);
            check($sformatf("rnd%0d_yQ", i), yQ, mQ);
            check($sformatf("rnd%0d_div0", i), dz, mdz);
            check($sformatf("rnd%0d_lat", i), lat, (mdz != 0) ? 2 : c_LAT);
        end

        // Reset in the middle of DIV, with a non-zero previous result on the outputs
        run_op(2048, 0, 1024, 0, yI, yQ, dz, lat);
        check("pre_rst_yI", yI, 2048);
        @(posedge clk); #1;
        i_valid = 1'b1;
        i_aI = 17'(2048); i_aQ = '0; i_bI = 17'(3072); i_bQ = '0;
        @(posedge clk); #1;
        i_valid = 1'b0;
        repeat (6) @(posedge clk);
        #1;
        check("middiv_valid", o_valid, 0);
        check("middiv_ready", o_ready, 0);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk); #1;
        check("midrst_valid", o_valid, 0);
        check("midrst_ready", o_ready, 1);
        check("midrst_yI", o_yI, 0);
        check("midrst_yQ", o_yQ, 0);
        check("midrst_div0", o_div0, 0);
        @(negedge clk);
        rst = 1'b0;
        run_op(tv[4].aI, tv[4].aQ, tv[4].bI, tv[4].bQ, yI, yQ, dz, lat);
        check("postrst_yI", yI, tv[4].eI);
        check("postrst_yQ", yQ, 0);
        check("postrst_div0", dz, 0);
        check("postrst_lat", lat, c_LAT);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
